// File: rtl/ph_receiver_if.sv
// Receive-side bundle between the USB line sampler and the host protocol FSM.
// The FSM (master) drives enable and the bus samples; the receiver reports events.
interface ph_receiver_if;
  logic        rx_enable;
  logic        DP_in;
  logic        DM_in;
  logic        rx_done;
  logic [3:0]  rx_pid;
  logic [63:0] rx_data;
  logic        rx_error;
  logic        rx_timeout;

  modport master (
    output rx_enable, DP_in, DM_in,
    input  rx_done, rx_pid, rx_data,
    input  rx_error, rx_timeout
  );

  modport slave (
    input  rx_enable, DP_in, DM_in,
    output rx_done, rx_pid, rx_data,
    output rx_error, rx_timeout
  );
endinterface

// File: rtl/ph_receiver.sv
// Host-side USB packet receiver: NRZI decode, SYNC detect, bit unstuffing,
// PID/DATA0 parsing with CRC16 and EOP checks, reported as one-cycle pulses.
module ph_receiver #(
  parameter int TIMEOUT_CLKS = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  ph_receiver_if.slave bus
);

  localparam int TW =
    (TIMEOUT_CLKS < 2) ? 1 : $clog2(TIMEOUT_CLKS);
  localparam logic [TW-1:0] TLAST =
    TW'(TIMEOUT_CLKS - 1);

  localparam logic [1:0] LJ   = 2'b10;
  localparam logic [1:0] LK   = 2'b01;
  localparam logic [1:0] LSE0 = 2'b00;
  localparam logic [1:0] LSE1 = 2'b11;

  localparam logic [3:0] PID_ACK = 4'b0010;
  localparam logic [3:0] PID_NAK = 4'b1010;
  localparam logic [3:0] PID_D0  = 4'b0011;

  localparam logic [15:0] CRC_POLY = 16'h8005;
  localparam logic [15:0] CRC_RES  = 16'h800D;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WSYNC,
    S_SYNC,
    S_PID,
    S_PAY,
    S_EOP,
    S_WIDLE
  } state_t;

  state_t        r_state;
  logic [1:0]    r_line;
  logic [1:0]    r_ref;
  logic [2:0]    r_ones;
  logic [6:0]    r_cnt;
  logic [TW-1:0] r_tcnt;
  logic [6:0]    r_pid_sh;
  logic [3:0]    r_pid_cur;
  logic [15:0]   r_crc;
  logic [63:0]   r_shadow;
  logic          r_done;
  logic          r_err;
  logic          r_tmo;
  logic [3:0]    r_pid_o;
  logic [63:0]   r_data_o;

  logic        w_jk;
  logic        w_bit;
  logic        w_stuff;
  logic [7:0]  w_pid;
  logic        w_pid_ok;
  logic [2:0]  w_ones_nx;
  logic [15:0] w_crc_nx;
  logic [5:0]  w_didx;

  assign w_jk    = (r_line == LJ) || (r_line == LK);
  assign w_bit   = (r_line == r_ref);
  assign w_stuff = (r_ones == 3'd6);
  assign w_pid   = {w_bit, r_pid_sh};

  assign w_pid_ok =
    (w_pid[7:4] == ~w_pid[3:0]) &&
    ((w_pid[3:0] == PID_ACK) ||
     (w_pid[3:0] == PID_NAK) ||
     (w_pid[3:0] == PID_D0));

  assign w_ones_nx =
    w_bit ? r_ones + 3'd1 : 3'd0;

  assign w_crc_nx =
    {r_crc[14:0], 1'b0} ^
    ((w_bit ^ r_crc[15]) ? CRC_POLY : 16'h0);

  // first byte lands in [63:56], each byte LSB first
  assign w_didx = {~r_cnt[5:3], r_cnt[2:0]};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_line    <= LJ;
      r_ref     <= LJ;
      r_ones    <= '0;
      r_cnt     <= '0;
      r_tcnt    <= '0;
      r_pid_sh  <= '0;
      r_pid_cur <= '0;
      r_crc     <= '0;
      r_shadow  <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_tmo     <= 1'b0;
      r_pid_o   <= '0;
      r_data_o  <= '0;
    end else begin
      r_line <= {bus.DP_in, bus.DM_in};
      r_done <= 1'b0;
      r_err  <= 1'b0;
      r_tmo  <= 1'b0;
      if (!bus.rx_enable) begin
        r_state <= S_IDLE;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            r_state <= S_WSYNC;
            r_ref   <= LJ;
            r_tcnt  <= '0;
          end
          S_WSYNC: begin
            if (r_line == LK) begin
              r_state <= S_SYNC;
              r_ref   <= LK;
              r_ones  <= '0;
              r_cnt   <= 7'd1;
            end else if (r_tcnt == TLAST) begin
              r_tmo   <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_tcnt <= r_tcnt + 1'b1;
            end
          end
          S_SYNC, S_PID, S_PAY: begin
            if (!w_jk) begin
              r_err   <= 1'b1;
              r_state <= S_WIDLE;
              r_cnt   <= '0;
            end else if (w_stuff) begin
              r_ref <= r_line;
              if (w_bit) begin
                r_err   <= 1'b1;
                r_state <= S_WIDLE;
                r_cnt   <= '0;
              end else begin
                r_ones <= '0;
              end
            end else begin
              r_ref  <= r_line;
              r_ones <= w_ones_nx;
              if (r_state == S_SYNC) begin
                if (w_bit != (r_cnt == 7'd7)) begin
                  r_err   <= 1'b1;
                  r_state <= S_WIDLE;
                  r_cnt   <= '0;
                end else if (r_cnt == 7'd7) begin
                  r_state <= S_PID;
                  r_cnt   <= '0;
                end else begin
                  r_cnt <= r_cnt + 7'd1;
                end
              end else if (r_state == S_PID) begin
                r_pid_sh <= w_pid[7:1];
                if (r_cnt != 7'd7) begin
                  r_cnt <= r_cnt + 7'd1;
                end else if (!w_pid_ok) begin
                  r_err   <= 1'b1;
                  r_state <= S_WIDLE;
                  r_cnt   <= '0;
                end else begin
                  r_pid_cur <= w_pid[3:0];
                  r_cnt     <= '0;
                  r_crc     <= 16'hFFFF;
                  r_state   <= (w_pid[3:0] == PID_D0)
                               ? S_PAY : S_EOP;
                end
              end else begin
                r_crc <= w_crc_nx;
                if (!r_cnt[6])
                  r_shadow[w_didx] <= w_bit;
                if (r_cnt == 7'd79) begin
                  r_state <= S_EOP;
                  r_cnt   <= '0;
                end else begin
                  r_cnt <= r_cnt + 7'd1;
                end
              end
            end
          end
          S_EOP: begin
            // a run of six 1s at the end of CRC still owes a stuffed 0
            if (r_line == LSE1) begin
              r_err   <= 1'b1;
              r_state <= S_WIDLE;
              r_cnt   <= '0;
            end else if (w_stuff) begin
              if (w_jk && !w_bit) begin
                r_ones <= '0;
                r_ref  <= r_line;
              end else begin
                r_err   <= 1'b1;
                r_state <= S_WIDLE;
                r_cnt   <= '0;
              end
            end else if (r_cnt != 7'd2) begin
              if (r_line == LSE0) begin
                r_cnt <= r_cnt + 7'd1;
              end else begin
                r_err   <= 1'b1;
                r_state <= S_WIDLE;
                r_cnt   <= '0;
              end
            end else if ((r_line != LJ) ||
                         ((r_pid_cur == PID_D0) &&
                          (r_crc != CRC_RES))) begin
              r_err   <= 1'b1;
              r_state <= S_WIDLE;
              r_cnt   <= '0;
            end else begin
              r_done  <= 1'b1;
              r_pid_o <= r_pid_cur;
              if (r_pid_cur == PID_D0)
                r_data_o <= r_shadow;
              r_state <= S_WSYNC;
              r_ref   <= LJ;
              r_tcnt  <= '0;
            end
          end
          S_WIDLE: begin
            if (r_line == LJ) begin
              if (r_cnt == 7'd7) begin
                r_state <= S_WSYNC;
                r_ref   <= LJ;
                r_tcnt  <= '0;
              end else begin
                r_cnt <= r_cnt + 7'd1;
              end
            end else begin
              r_cnt <= '0;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.rx_done    = r_done;
  assign bus.rx_error   = r_err;
  assign bus.rx_timeout = r_tmo;
  assign bus.rx_pid     = r_pid_o;
  assign bus.rx_data    = r_data_o;

endmodule

// File: tb/tb_ph_receiver.sv
// Scoreboard bench for ph_receiver: builds NRZI/stuffed line streams,
// queues expected events and checks them in a separate monitor.
module tb_ph_receiver;

  localparam logic [1:0] J   = 2'b10;
  localparam logic [1:0] K   = 2'b01;
  localparam logic [1:0] SE0 = 2'b00;

  typedef struct {
    int          kind;
    int          cyc;
    logic [3:0]  pid;
    logic [63:0] data;
  } ev_t;

  logic clock;
  logic reset_n;
  int   cyc;
  int   checks;
  int   errors;
  ev_t  sb[$];
  logic [1:0] pk[$];
  int   ev_idx;
  logic [3:0]  lpid;
  logic [63:0] ldata;

  ph_receiver_if bus ();

  ph_receiver #(.TIMEOUT_CLKS(255)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  function automatic logic [1:0] tog(input logic [1:0] l);
    return (l == J) ? K : J;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      {bus.DP_in, bus.DM_in} = J;
    end
  endtask

  task automatic build(input logic [7:0] pid,
                       input bit hasd,
                       input logic [63:0] data,
                       input int flip,
                       input bit force1,
                       input int se0_at,
                       input bit pid_bad);
    logic dec[$];
    int tg[$];
    logic [15:0] c;
    logic b, fb;
    logic [1:0] lvl;
    int ones;
    bit stuffed;
    for (int i = 0; i < 8; i++) begin
      dec.push_back(i == 7);
      tg.push_back(-1);
    end
    for (int i = 0; i < 8; i++) begin
      dec.push_back(pid[i]);
      tg.push_back(-1);
    end
    if (hasd) begin
      c = 16'hFFFF;
      for (int k = 0; k < 8; k++)
        for (int j = 0; j < 8; j++) begin
          b  = data[(7-k)*8+j];
          fb = b ^ c[15];
          c  = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0);
          dec.push_back(b ^ logic'(k*8+j == flip));
          tg.push_back(k*8+j);
        end
      for (int i = 15; i >= 0; i--) begin
        dec.push_back(~c[i]);
        tg.push_back(-1);
      end
    end
    pk.delete();
    ev_idx = -1;
    lvl = J;
    ones = 0;
    stuffed = 0;
    foreach (dec[i]) begin
      if (se0_at >= 0 && tg[i] == se0_at) begin
        pk.push_back(SE0);
        if (ev_idx < 0) ev_idx = pk.size() - 1;
      end else begin
        if (!dec[i]) lvl = tog(lvl);
        pk.push_back(lvl);
      end
      if (pid_bad && i == 15 && ev_idx < 0)
        ev_idx = pk.size() - 1;
      ones = dec[i] ? ones + 1 : 0;
      if (ones == 6) begin
        ones = 0;
        if (force1 && !stuffed) begin
          pk.push_back(lvl);
          if (ev_idx < 0) ev_idx = pk.size() - 1;
        end else begin
          lvl = tog(lvl);
          pk.push_back(lvl);
        end
        stuffed = 1;
      end
    end
    pk.push_back(SE0);
    pk.push_back(SE0);
    pk.push_back(J);
    if (ev_idx < 0) ev_idx = pk.size() - 1;
  endtask

  task automatic send(input int n, input int kind,
                      input logic [3:0] epid,
                      input logic [63:0] edata);
    ev_t e;
    for (int i = 0; i < n && i < pk.size(); i++) begin
      @(negedge clock);
      {bus.DP_in, bus.DM_in} = pk[i];
      if (i == ev_idx && kind != 0) begin
        e.kind = kind;
        e.cyc  = cyc + 2;
        e.pid  = epid;
        e.data = edata;
        sb.push_back(e);
      end
    end
  endtask

  task automatic run(input logic [7:0] pid,
                     input bit hasd,
                     input logic [63:0] data,
                     input int flip, input bit f1,
                     input int se0, input bit pbad,
                     input int kind, input bit keep);
    logic [3:0] ep;
    logic [63:0] ed;
    @(negedge clock);
    bus.rx_enable = 1'b1;
    idle(2);
    build(pid, hasd, data, flip, f1, se0, pbad);
    ep = (kind == 1) ? pid[3:0] : lpid;
    ed = (kind == 1 && hasd) ? data : ldata;
    send(pk.size(), kind, ep, ed);
    if (kind == 1) begin
      lpid  = ep;
      ldata = ed;
    end
    idle(10);
    if (!keep) begin
      @(negedge clock);
      bus.rx_enable = 1'b0;
      idle(3);
    end
  endtask

  initial begin : monitor
    ev_t e;
    int  n;
    int  kind;
    forever begin
      @(negedge clock);
      if (reset_n && (bus.rx_done || bus.rx_error ||
                      bus.rx_timeout)) begin
        n = int'(bus.rx_done) + int'(bus.rx_error) +
            int'(bus.rx_timeout);
        kind = bus.rx_done ? 1 : (bus.rx_error ? 2 : 3);
        chk("pulse_exclusive", n, 1);
        if (sb.size() == 0) begin
          chk("unexpected_event", kind, 0);
        end else begin
          e = sb.pop_front();
          chk("event_kind", kind, e.kind);
          chk("event_cycle", cyc, e.cyc);
          chk("rx_pid", bus.rx_pid, e.pid);
          chk("rx_data", bus.rx_data, e.data);
        end
      end
    end
  end

  initial begin : stim
    checks = 0;
    errors = 0;
    lpid   = '0;
    ldata  = '0;
    reset_n = 1'b0;
    bus.rx_enable = 1'b0;
    {bus.DP_in, bus.DM_in} = J;
    repeat (3) @(negedge clock);
    chk("reset_done", bus.rx_done, 0);
    chk("reset_error", bus.rx_error, 0);
    chk("reset_timeout", bus.rx_timeout, 0);
    chk("reset_pid", bus.rx_pid, 0);
    chk("reset_data", bus.rx_data, 0);
    reset_n = 1'b1;
    idle(2);

    run(8'hD2, 0, 64'h0, -1, 0, -1, 0, 1, 0);
    run(8'hC3, 1, 64'h40aa11b7682df6d8,
        -1, 0, -1, 0, 1, 0);
    run(8'hC3, 1, 64'hfef811b7682df6d8,
        -1, 0, -1, 0, 1, 0);
    run(8'hC3, 1, 64'hfef811b7682df6d8,
        -1, 1, -1, 0, 2, 0);
    run(8'hC3, 1, 64'h40aa11b7682df6d8,
        5, 0, -1, 0, 2, 0);
    run(8'hC3, 1, 64'h40aa11b7682df6d8,
        -1, 0, 20, 0, 2, 1);
    run(8'hD2, 0, 64'h0, -1, 0, -1, 0, 1, 0);
    run(8'h5B, 0, 64'h0, -1, 0, -1, 1, 2, 0);
    run(8'h5A, 0, 64'h0, -1, 0, -1, 0, 1, 0);

    begin : timeout_test
      ev_t e;
      @(negedge clock);
      bus.rx_enable = 1'b1;
      e.kind = 3;
      e.cyc  = cyc + 256;
      e.pid  = lpid;
      e.data = ldata;
      sb.push_back(e);
      idle(258);
      bus.rx_enable = 1'b0;
      idle(3);
    end

    @(negedge clock);
    bus.rx_enable = 1'b1;
    idle(2);
    build(8'hC3, 1, 64'h123456789abcdef0, -1, 0, -1, 0);
    send(40, 0, lpid, ldata);
    @(negedge clock);
    bus.rx_enable = 1'b0;
    idle(5);
    chk("abort_data", bus.rx_data, ldata);
    chk("abort_pid", bus.rx_pid, lpid);

    @(negedge clock);
    bus.rx_enable = 1'b1;
    idle(2);
    build(8'hC3, 1, 64'h0123456789abcdef, -1, 0, -1, 0);
    send(30, 0, lpid, ldata);
    #2 reset_n = 1'b0;
    #1;
    chk("areset_done", bus.rx_done, 0);
    chk("areset_error", bus.rx_error, 0);
    chk("areset_timeout", bus.rx_timeout, 0);
    chk("areset_pid", bus.rx_pid, 0);
    chk("areset_data", bus.rx_data, 0);
    bus.rx_enable = 1'b0;
    lpid  = '0;
    ldata = '0;
    idle(2);
    reset_n = 1'b1;
    idle(2);
    run(8'hD2, 0, 64'h0, -1, 0, -1, 0, 1, 0);

    repeat (20) @(negedge clock);
    chk("scoreboard_drain", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
